// File: rtl/mem_bank_arb_pkg.sv
// Shared types and helpers for the two-port memory bank arbiter.
// Port-select encoding and pointer sizing live here.
package mem_bank_arb_pkg;

    typedef enum logic [1:0] {
        PORT_NONE = 2'd0,
        PORT_RW0  = 2'd1,
        PORT_RW1  = 2'd2
    } port_sel_e;

    function automatic int ptr_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mem_bank_rr_pick.sv
// Rotate-priority picker: first set bit of valid at or after start,
// wrapping modulo N.
module mem_bank_rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  valid,
    input  logic [PW-1:0] start,
    output logic          found,
    output logic [PW-1:0] idx
);

    logic [N-1:0] rot;
    logic [PW:0]  pos;
    logic [PW:0]  sum;

    always_comb begin
        rot = N'({valid, valid} >> start);
        pos = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) pos = (PW+1)'(k);
        end
        sum = pos + {1'b0, start};
        if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
        found = |valid;
        idx   = sum[PW-1:0];
    end

endmodule

// File: rtl/mem_bank_2rw_arb.sv
// Round-robin arbiter mapping up to two requesters per cycle onto the
// two read/write ports of a register bank, with one-cycle responses.
module mem_bank_2rw_arb
    import mem_bank_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int REG_DEPTH = 4,
    parameter int REG_WIDTH = 64,
    localparam int AW = $clog2(REG_DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_wmode,
    input  logic [NUM_REQ*AW-1:0]        req_addr,
    input  logic [NUM_REQ*REG_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [NUM_REQ*REG_WIDTH-1:0] rsp_rdata,
    output logic                         RW0_wmode,
    output logic [AW-1:0]                RW0_addr,
    output logic [REG_WIDTH-1:0]         RW0_wdata,
    input  logic [REG_WIDTH-1:0]         RW0_rdata,
    output logic                         RW1_wmode,
    output logic [AW-1:0]                RW1_addr,
    output logic [REG_WIDTH-1:0]         RW1_wdata,
    input  logic [REG_WIDTH-1:0]         RW1_rdata
);

    localparam int PW = ptr_width(NUM_REQ);

    logic [PW-1:0]        rr_ptr;
    logic [PW-1:0]        g0;
    logic [PW-1:0]        g1;
    logic [PW-1:0]        last;
    logic                 g0_found;
    logic                 g1_found;
    logic                 g1_clash;
    logic                 use0;
    logic                 use1;
    logic [NUM_REQ-1:0]   rest_valid;
    logic [NUM_REQ-1:0]   rsp_q;
    logic [AW-1:0]        addr_a  [NUM_REQ];
    logic [REG_WIDTH-1:0] wdata_a [NUM_REQ];
    logic [REG_WIDTH-1:0] rdata_q [NUM_REQ];
    port_sel_e            sel     [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_a[i]  = req_addr[i*AW +: AW];
        assign wdata_a[i] = req_wdata[i*REG_WIDTH +: REG_WIDTH];
        assign rsp_rdata[i*REG_WIDTH +: REG_WIDTH] = rdata_q[i];
    end

    mem_bank_rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick0 (
        .valid (req_valid),
        .start (rr_ptr),
        .found (g0_found),
        .idx   (g0)
    );

    assign rest_valid = req_valid & ~(NUM_REQ'(1) << g0);

    mem_bank_rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick1 (
        .valid (rest_valid),
        .start (g0),
        .found (g1_found),
        .idx   (g1)
    );

    always_comb begin
        // A write on either side makes a shared address unsafe for one cycle
        g1_clash = (addr_a[g1] == addr_a[g0]) &&
                   (req_wmode[g0] || req_wmode[g1]);
        use0 = rst_n && g0_found;
        use1 = use0 && g1_found && !g1_clash;
        last = use1 ? g1 : g0;

        RW0_wmode = use0 && req_wmode[g0];
        RW0_addr  = use0 ? addr_a[g0]  : '0;
        RW0_wdata = use0 ? wdata_a[g0] : '0;
        RW1_wmode = use1 && req_wmode[g1];
        RW1_addr  = use1 ? addr_a[g1]  : '0;
        RW1_wdata = use1 ? wdata_a[g1] : '0;

        for (int i = 0; i < NUM_REQ; i++) begin
            sel[i] = PORT_NONE;
            if (use0 && g0 == PW'(i)) sel[i] = PORT_RW0;
            else if (use1 && g1 == PW'(i)) sel[i] = PORT_RW1;
            req_ready[i] = (sel[i] != PORT_NONE);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            rsp_q  <= '0;
            for (int i = 0; i < NUM_REQ; i++) rdata_q[i] <= '0;
        end else begin
            rsp_q <= req_ready;
            if (use0) begin
                rr_ptr <= (last == PW'(NUM_REQ - 1)) ? '0 : last + 1'b1;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                case (sel[i])
                    PORT_RW0: rdata_q[i] <= RW0_rdata;
                    PORT_RW1: rdata_q[i] <= RW1_rdata;
                    default:  rdata_q[i] <= rdata_q[i];
                endcase
            end
        end
    end

    // A response owed across a reset edge is suppressed immediately
    assign rsp_valid = rsp_q & {NUM_REQ{rst_n}};

endmodule

// File: tb/tb_mem_bank_2rw_arb.sv
// Randomized and directed bench for mem_bank_2rw_arb against a
// behavioural arbiter/bank model.
module tb_mem_bank_2rw_arb;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req_valid = 4'hF;
    logic [3:0]   req_wmode = 4'hF;
    logic [7:0]   req_addr = '0;
    logic [255:0] req_wdata = '0;
    logic [3:0]   req_ready;
    logic [3:0]   rsp_valid;
    logic [255:0] rsp_rdata;
    logic         RW0_wmode, RW1_wmode;
    logic [1:0]   RW0_addr, RW1_addr;
    logic [63:0]  RW0_wdata, RW1_wdata, RW0_rdata, RW1_rdata;

    logic [63:0]  mem   [4];
    logic [63:0]  m_mem [4];
    logic [63:0]  m_rd  [4];
    logic [3:0]   m_rsp = '0;
    int           m_ptr = 0;
    int           total = 0;
    int           bad = 0;
    int           cnt [4];

    always #5 clk = ~clk;

    mem_bank_2rw_arb #(.NUM_REQ(4), .REG_DEPTH(4), .REG_WIDTH(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_wmode(req_wmode),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .RW0_wmode(RW0_wmode), .RW0_addr(RW0_addr),
        .RW0_wdata(RW0_wdata), .RW0_rdata(RW0_rdata),
        .RW1_wmode(RW1_wmode), .RW1_addr(RW1_addr),
        .RW1_wdata(RW1_wdata), .RW1_rdata(RW1_rdata)
    );

    assign RW0_rdata = mem[RW0_addr];
    assign RW1_rdata = mem[RW1_addr];

    always @(posedge clk) begin
        if (RW0_wmode) mem[RW0_addr] <= RW0_wdata;
        if (RW1_wmode) mem[RW1_addr] <= RW1_wdata;
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] ad(input int i);
        return req_addr[i*2 +: 2];
    endfunction

    function automatic logic [63:0] wd(input int i);
        return req_wdata[i*64 +: 64];
    endfunction

    function automatic logic [63:0] rd(input int i);
        return rsp_rdata[i*64 +: 64];
    endfunction

    // Model: compare every cycle, then advance the model's state
    always @(negedge clk) begin
        int g0, g1, j;
        bit f0, f1;
        logic [3:0] er;
        logic [63:0] e0d, e1d;
        logic [1:0] e0a, e1a;
        logic e0w, e1w;
        f0 = 0; f1 = 0; g0 = 0; g1 = 0; er = '0;
        e0w = 0; e1w = 0; e0a = '0; e1a = '0; e0d = '0; e1d = '0;
        if (rst_n) begin
            for (int k = 0; k < 4; k++) begin
                j = (m_ptr + k) % 4;
                if (!f0 && req_valid[j]) begin f0 = 1; g0 = j; end
            end
            if (f0) begin
                for (int k = 1; k < 4; k++) begin
                    j = (g0 + k) % 4;
                    if (!f1 && req_valid[j]) begin f1 = 1; g1 = j; end
                end
            end
            if (f1 && ad(g0) == ad(g1) && (req_wmode[g0] || req_wmode[g1]))
                f1 = 0;
        end
        if (f0) begin
            er[g0] = 1'b1;
            e0w = req_wmode[g0]; e0a = ad(g0); e0d = wd(g0);
        end
        if (f1) begin
            er[g1] = 1'b1;
            e1w = req_wmode[g1]; e1a = ad(g1); e1d = wd(g1);
        end
        chk("ready", 64'(req_ready), 64'(er));
        chk("rw0_wmode", 64'(RW0_wmode), 64'(e0w));
        chk("rw0_addr", 64'(RW0_addr), 64'(e0a));
        chk("rw0_wdata", RW0_wdata, e0d);
        chk("rw1_wmode", 64'(RW1_wmode), 64'(e1w));
        chk("rw1_addr", 64'(RW1_addr), 64'(e1a));
        chk("rw1_wdata", RW1_wdata, e1d);
        chk("rsp_valid", 64'(rsp_valid), 64'(m_rsp & {4{rst_n}}));
        for (int i = 0; i < 4; i++) chk("rsp_rdata", rd(i), m_rd[i]);
        chk("rr_ptr", 64'(dut.rr_ptr), 64'(m_ptr));
        if (!rst_n) begin
            m_ptr = 0;
            m_rsp = '0;
            for (int i = 0; i < 4; i++) m_rd[i] = '0;
        end else begin
            m_rsp = er;
            if (f0) m_rd[g0] = m_mem[ad(g0)];
            if (f1) m_rd[g1] = m_mem[ad(g1)];
            if (f0 && req_wmode[g0]) m_mem[ad(g0)] = wd(g0);
            if (f1 && req_wmode[g1]) m_mem[ad(g1)] = wd(g1);
            if (f0) m_ptr = ((f1 ? g1 : g0) + 1) % 4;
        end
    end

    task automatic step(input logic r, input logic [3:0] v,
                        input logic [3:0] w, input logic [7:0] a,
                        input logic [255:0] d);
        @(posedge clk);
        #1;
        rst_n = r; req_valid = v; req_wmode = w;
        req_addr = a; req_wdata = d;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            mem[i] = 64'h1000 + 64'(i);
            m_mem[i] = 64'h1000 + 64'(i);
            m_rd[i] = '0;
            cnt[i] = 0;
        end

        step(1'b0, 4'hF, 4'hF, 8'h00, '0);
        chk("rst_ready", 64'(req_ready), 64'h0);
        chk("rst_rsp", 64'(rsp_valid), 64'h0);
        chk("rst_rw0", 64'(RW0_wmode), 64'h0);
        chk("rst_rw1", 64'(RW1_wmode), 64'h0);
        chk("rst_ptr", 64'(dut.rr_ptr), 64'h0);

        step(1'b1, 4'h0, 4'h0, 8'h00, '0);

        // req0 writes 0xAA to addr1, req2 reads addr2
        step(1'b1, 4'b0101, 4'b0001, 8'b00_10_00_01,
             {64'h0, 64'h0, 64'h0, 64'hAA});
        chk("dual_ready", 64'(req_ready), 64'b0101);
        chk("dual_rw0", {62'h0, RW0_wmode, RW0_addr[0]}, 64'b11);
        chk("dual_rw1", {61'h0, RW1_wmode, RW1_addr}, 64'b010);

        // req1 writes addr3 while req2 reads addr3
        step(1'b1, 4'b0110, 4'b0010, 8'b00_11_11_00,
             {64'h0, 64'h0, 64'h55, 64'h0});
        chk("dual_rsp", 64'(rsp_valid), 64'b0101);
        chk("dual_rd0", rd(0), 64'h1001);
        chk("dual_rd2", rd(2), 64'h1002);
        chk("dual_ptr", 64'(dut.rr_ptr), 64'd3);
        chk("clash_ready", 64'(req_ready), 64'b0010);

        step(1'b1, 4'b0100, 4'b0000, 8'b00_11_00_00, '0);
        chk("clash_retry", 64'(req_ready), 64'b0100);
        chk("clash_rd1", rd(1), 64'h1003);

        // reqs 0 and 1 both read addr2
        step(1'b1, 4'b0011, 4'b0000, 8'b00_00_10_10, '0);
        chk("clash_rsp2", 64'(rsp_valid), 64'b0100);
        chk("clash_rd2", rd(2), 64'h55);
        chk("rr_ready", 64'(req_ready), 64'b0011);

        step(1'b1, 4'b1000, 4'b0000, 8'h00, '0);
        chk("rr_rsp", 64'(rsp_valid), 64'b0011);
        chk("rr_rd0", rd(0), 64'h1002);
        chk("rr_rd1", rd(1), 64'h1002);

        for (int c = 0; c < 8; c++) begin
            step(1'b1, 4'hF, 4'h0, 8'h00, '0);
            chk("fair_pair", 64'(req_ready), (c % 2 == 0) ? 64'b0011 : 64'b1100);
            for (int i = 0; i < 4; i++) if (req_ready[i]) cnt[i]++;
        end
        for (int i = 0; i < 4; i++) chk("fair_count", 64'(cnt[i]), 64'd4);

        // grant req3, then reset the following cycle
        step(1'b1, 4'b1000, 4'b0000, 8'h00, '0);
        chk("mid_ready", 64'(req_ready), 64'b1000);
        step(1'b0, 4'b0000, 4'b0000, 8'h00, '0);
        chk("mid_rsp", 64'(rsp_valid), 64'h0);
        step(1'b1, 4'b0000, 4'b0000, 8'h00, '0);
        chk("mid_rsp2", 64'(rsp_valid), 64'h0);
        chk("mid_ptr", 64'(dut.rr_ptr), 64'h0);

        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 63) != 0), 4'($urandom), 4'($urandom),
                 8'($urandom),
                 {$urandom, $urandom, $urandom, $urandom,
                  $urandom, $urandom, $urandom, $urandom});
        end
        step(1'b1, 4'h0, 4'h0, 8'h00, '0);
        step(1'b1, 4'h0, 4'h0, 8'h00, '0);
        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_bank_2rw_arb.md
MEM_BANK_2RW_ARB -- requirements
Module: mem_bank_2rw_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters, range 2..8.
REQ-002 SHALL have parameter REG_DEPTH, default 4: entries in the attached 2-port bank.
REQ-003 SHALL have parameter REG_WIDTH, default 64: entry width in bits.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port req_valid, input, NUM_REQ: per-requester request pending.
REQ-007 SHALL have port req_wmode, input, NUM_REQ: per-requester 1=write, 0=read.
REQ-008 SHALL have port req_addr, input, NUM_REQ*$clog2(REG_DEPTH): packed addresses, requester i in slice i.
REQ-009 SHALL have port req_wdata, input, NUM_REQ*REG_WIDTH: packed write data.
REQ-010 SHALL have port req_ready, output, NUM_REQ: grant; request i completes in a cycle where req_valid[i] and req_ready[i] are both high.
REQ-011 SHALL have port rsp_valid, output, NUM_REQ: response strobe for requester i.
REQ-012 SHALL have port rsp_rdata, output, NUM_REQ*REG_WIDTH: packed response data.
REQ-013 SHALL have ports RW0_wmode, RW0_addr and RW0_wdata as outputs, and RW0_rdata as an input, sized to match the bank's port 0.
REQ-014 SHALL have ports RW1_wmode, RW1_addr and RW1_wdata as outputs, and RW1_rdata as an input, for the bank's port 1.

Function
REQ-015 SHALL grant at most two requesters per cycle, combinationally from req_valid and the round-robin pointer rr_ptr.
REQ-016 SHALL choose the first grant g0 as the lowest index at or after rr_ptr, modulo NUM_REQ, with req_valid set; g0 SHALL drive port RW0.
REQ-017 SHALL choose the second grant g1 as the next valid index after g0, modulo NUM_REQ, excluding g0; g1 SHALL drive port RW1.
REQ-018 SHALL withhold g1 that cycle when g1's address equals g0's address and either request is a write; the withheld request stays pending.
REQ-019 SHALL leave g1 granted when both requests are reads to the same address.
REQ-020 SHALL advance rr_ptr to (last granted index + 1) mod NUM_REQ when any request is granted, and SHALL leave rr_ptr unchanged otherwise.
REQ-021 SHALL drive an unused memory port with wmode=0, addr=0 and wdata=0.
REQ-022 SHALL make req_ready combinational from req_valid; req_ready[i] SHALL never be high while req_valid[i] is low.
REQ-023 SHALL pulse rsp_valid[i] for exactly 1 cycle, 1 cycle after requester i is granted; this latency is fixed.
REQ-024 SHALL register rsp_rdata[i] from the granted port's RWx_rdata in the grant cycle, i.e. the pre-write contents; writes also receive a response.
REQ-025 SHALL hold rsp_rdata[i] until requester i's next response.
REQ-026 SHALL serve a requester re-requesting in the cycle after its grant normally, with no bubble.
REQ-027 SHALL bound starvation: a continuously valid requester is granted within NUM_REQ cycles.

Reset
REQ-028 SHALL, while rst_n=0 at a clock edge, set rr_ptr=0, rsp_valid=0 and rsp_rdata=0.
REQ-029 SHALL force req_ready=0 and idle both memory ports while rst_n=0.
REQ-030 SHALL drop any response owed for a grant in the cycle before reset is asserted.

Structure
REQ-031 SHALL place in package mem_bank_arb_pkg: the port-select enum (PORT_NONE, PORT_RW0, PORT_RW1) and a function returning the pointer width for a given NUM_REQ.
REQ-032 SHALL use a single sub-module, mem_bank_rr_pick: a combinational rotate-priority picker instantiated twice, for g0 and then for g1 with g0 masked out.

Verification
REQ-033 SHALL cover reset: drive rst_n=0 with all req_valid=1 -> req_ready=0, rsp_valid=0, RW0/RW1 wmode=0, rr_ptr=0.
REQ-034 SHALL cover dual grant: rr_ptr=0; req 0 writes addr1=0xAA; req 2 reads addr2 -> RW0 serves req 0, RW1 serves req 2; rsp_valid[0] and rsp_valid[2] pulse the next cycle; rr_ptr=3.
REQ-035 SHALL cover write conflict: req 1 writes addr3; req 2 reads addr3 -> only req 1 granted; req 2 granted the next cycle and reads the new value.
REQ-036 SHALL cover same-address reads: reqs 0 and 1 both read addr2 -> both granted in the same cycle; both return identical rdata.
REQ-037 SHALL cover fairness: all 4 requesters valid continuously for 8 cycles -> each is granted exactly 4 times, grant pairs {0,1},{2,3} alternating.
REQ-038 SHALL cover reset mid-operation: grant req 3 in cycle N, assert rst_n=0 in cycle N+1 -> rsp_valid[3] does not pulse; rr_ptr=0 after reset.
